// File: rtl/wram_oam_dma_ctrl.sv
// WRAM port arbiter between the CPU and the sprite (OAM) DMA engine.
// DMA stalls the CPU and copies one WRAM page into OAM at one byte per cycle.
module wram_oam_dma_ctrl #(
  parameter int unsigned DMA_LEN      = 256,
  parameter int unsigned ALIGN_CYCLES = 1
) (
  input  logic        i_clk_cpu,
  input  logic        i_reset,
  input  logic        i_cpu_ce,
  input  logic        i_cpu_rnw,
  input  logic [10:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_dma_start,
  input  logic [2:0]  i_dma_page,
  output logic        o_dma_busy,
  output logic        o_dma_done,
  output logic        o_ram_ce,
  output logic        o_ram_rnw,
  output logic [10:0] o_ram_addr,
  output logic [7:0]  o_ram_wdata,
  input  logic [7:0]  i_ram_rdata,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_wdata
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned PAGE_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [ACNT_W-1:0]   align_cnt_q, align_cnt_d;

  logic                oam_we_q;
  logic [IDX_W-1:0]    oam_addr_q;
  logic [DATA_W-1:0]   oam_hold_q;
  logic                cpu_rd_q;
  logic [DATA_W-1:0]   cpu_hold_q;

  // State register and DMA bookkeeping
  always_ff @(posedge i_clk_cpu) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      page_q      <= '0;
      index_q     <= '0;
      align_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      index_q     <= index_d;
      align_cnt_q <= align_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    index_d     = index_q;
    align_cnt_d = align_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_dma_start) begin
          page_d      = i_dma_page;
          index_d     = '0;
          align_cnt_d = '0;
          state_d     = (ALIGN_CYCLES == 0) ? S_XFER : S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (align_cnt_q == ACNT_W'(ALIGN_CYCLES - 1)) begin
          state_d = S_XFER;
        end else begin
          align_cnt_d = align_cnt_q + ACNT_W'(1);
        end
      end
      S_XFER: begin
        // Index is 8 bits, so a full 256-byte page wraps it back to zero.
        index_d = index_q + IDX_W'(1);
        if (index_q == IDX_W'(DMA_LEN - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: RAM port mux, stall/busy/done
  always_comb begin
    o_ram_ce    = 1'b0;
    o_ram_rnw   = 1'b1;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_cpu_stall = (state_q != S_IDLE);
    o_dma_busy  = (state_q != S_IDLE);
    o_dma_done  = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        o_ram_ce    = i_cpu_ce & ~i_reset;
        o_ram_rnw   = i_cpu_rnw | i_reset;
        o_ram_addr  = i_cpu_addr;
        o_ram_wdata = i_cpu_wdata;
      end
      S_XFER: begin
        o_ram_ce   = ~i_reset;
        o_ram_addr = {page_q, index_q};
      end
      default: ;
    endcase
  end

  // OAM write pipeline aligned with the RAM's one-cycle read latency
  always_ff @(posedge i_clk_cpu) begin
    if (i_reset) begin
      oam_we_q   <= 1'b0;
      oam_addr_q <= '0;
      oam_hold_q <= '0;
      cpu_rd_q   <= 1'b0;
      cpu_hold_q <= '0;
    end else begin
      oam_we_q <= (state_q == S_XFER);
      if (state_q == S_XFER) oam_addr_q <= index_q;
      if (oam_we_q) oam_hold_q <= i_ram_rdata;
      cpu_rd_q <= (state_q == S_IDLE) & i_cpu_ce & i_cpu_rnw;
      if (cpu_rd_q) cpu_hold_q <= i_ram_rdata;
    end
  end

  assign o_oam_we    = oam_we_q;
  assign o_oam_addr  = oam_addr_q;
  assign o_oam_wdata = oam_we_q ? i_ram_rdata : oam_hold_q;
  // CPU read data only tracks the RAM after a granted CPU read, so DMA reads never disturb it.
  assign o_cpu_rdata = cpu_rd_q ? i_ram_rdata : cpu_hold_q;

endmodule

// File: tb/tb_wram_oam_dma_ctrl.sv
// Directed bench for wram_oam_dma_ctrl with a behavioural 2KB synchronous WRAM
// and a negedge monitor that records OAM writes, stall runs and done pulses.
module tb_wram_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_cpu_ce, i_cpu_rnw;
  logic [10:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic [7:0]  o_cpu_rdata;
  logic        o_cpu_stall;
  logic        i_dma_start;
  logic [2:0]  i_dma_page;
  logic        o_dma_busy, o_dma_done;
  logic        o_ram_ce, o_ram_rnw;
  logic [10:0] o_ram_addr;
  logic [7:0]  o_ram_wdata;
  logic [7:0]  ram_rdata;
  logic        o_oam_we;
  logic [7:0]  o_oam_addr, o_oam_wdata;

  always #5 clk = ~clk;

  wram_oam_dma_ctrl #(.DMA_LEN(256), .ALIGN_CYCLES(1)) dut (
    .i_clk_cpu  (clk),
    .i_reset    (i_reset),
    .i_cpu_ce   (i_cpu_ce),
    .i_cpu_rnw  (i_cpu_rnw),
    .i_cpu_addr (i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_stall(o_cpu_stall),
    .i_dma_start(i_dma_start),
    .i_dma_page (i_dma_page),
    .o_dma_busy (o_dma_busy),
    .o_dma_done (o_dma_done),
    .o_ram_ce   (o_ram_ce),
    .o_ram_rnw  (o_ram_rnw),
    .o_ram_addr (o_ram_addr),
    .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(ram_rdata),
    .o_oam_we   (o_oam_we),
    .o_oam_addr (o_oam_addr),
    .o_oam_wdata(o_oam_wdata)
  );

  // Behavioural WRAM with registered read data
  logic [7:0] mem [2048];
  always @(posedge clk) begin
    if (o_ram_ce) begin
      if (!o_ram_rnw) mem[o_ram_addr] <= o_ram_wdata;
      else            ram_rdata       <= mem[o_ram_addr];
    end
  end

  // Monitor: OAM capture, ordering, stall run lengths, done pulses, illegal accesses
  logic [7:0] oam_mem [256];
  logic       prev_we = 1'b0;
  logic [7:0] prev_addr = 8'd0;
  logic [2:0] exp_page = 3'd0;
  int oam_wr_cnt = 0, order_err = 0, bad_acc = 0, done_cnt = 0;
  int run_cur = 0, last_run = 0, run_at_done = 0, stall_total = 0;

  always @(negedge clk) begin
    if (o_oam_we) begin
      oam_mem[o_oam_addr] <= o_oam_wdata;
      oam_wr_cnt <= oam_wr_cnt + 1;
      if (o_oam_addr != (prev_we ? prev_addr + 8'd1 : 8'd0)) order_err <= order_err + 1;
    end
    prev_we   <= o_oam_we;
    prev_addr <= o_oam_addr;
    if (o_cpu_stall) begin
      run_cur     <= run_cur + 1;
      stall_total <= stall_total + 1;
    end else if (run_cur != 0) begin
      last_run <= run_cur;
      run_cur  <= 0;
    end
    if (o_dma_done) begin
      done_cnt    <= done_cnt + 1;
      run_at_done <= run_cur + 1;
    end
    if (o_cpu_stall && o_ram_ce && (!o_ram_rnw || o_ram_addr[10:8] != exp_page))
      bad_acc <= bad_acc + 1;
  end

  int checks_total = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  logic [7:0] exp_oam [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    i_cpu_ce = 1'b1; i_cpu_rnw = 1'b0; i_cpu_addr = a; i_cpu_wdata = d;
    tick(1);
    i_cpu_ce = 1'b0; i_cpu_rnw = 1'b1;
  endtask

  task automatic cpu_read(input logic [10:0] a);
    i_cpu_ce = 1'b1; i_cpu_rnw = 1'b1; i_cpu_addr = a;
    tick(1);
    i_cpu_ce = 1'b0;
  endtask

  task automatic start_dma(input logic [2:0] p);
    i_dma_start = 1'b1; i_dma_page = p;
    tick(1);
    i_dma_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_cpu_stall && n < 400) begin
      tick(1);
      n++;
    end
    check(tag, 32'(o_cpu_stall), 32'd0);
    tick(2);
  endtask

  function automatic int count_mismatch();
    int m = 0;
    for (int i = 0; i < 256; i++) if (oam_mem[i] !== exp_oam[i]) m++;
    return m;
  endfunction

  int wr0, done0, st0, bad0;
  logic found;

  initial begin
    i_reset = 1'b1; i_cpu_ce = 1'b0; i_cpu_rnw = 1'b1; i_cpu_addr = '0;
    i_cpu_wdata = '0; i_dma_start = 1'b0; i_dma_page = '0;
    for (int i = 0; i < 256; i++) exp_oam[i] = 8'(i) ^ 8'h5A;
    tick(3);
    check("rst_stall", 32'(o_cpu_stall), 32'd0);
    check("rst_busy", 32'(o_dma_busy), 32'd0);
    check("rst_done", 32'(o_dma_done), 32'd0);
    check("rst_oam_we", 32'(o_oam_we), 32'd0);
    check("rst_cpu_rdata", 32'(o_cpu_rdata), 32'h00);
    check("rst_oam_addr", 32'(o_oam_addr), 32'h00);
    check("rst_oam_wdata", 32'(o_oam_wdata), 32'h00);
    check("rst_ram_ce", 32'(o_ram_ce), 32'd0);
    check("rst_ram_rnw", 32'(o_ram_rnw), 32'd1);
    i_reset = 1'b0;
    tick(1);

    // CPU write then read through the controller
    st0 = stall_total;
    cpu_write(11'h123, 8'hA5);
    cpu_read(11'h123);
    check("cpu_rd_123", 32'(o_cpu_rdata), 32'hA5);
    tick(1);
    check("cpu_rd_hold", 32'(o_cpu_rdata), 32'hA5);
    check("no_stall_cpu", 32'(stall_total - st0), 32'd0);

    // Full page-3 transfer
    for (int i = 0; i < 256; i++) cpu_write({3'd3, 8'(i)}, 8'(i) ^ 8'h5A);
    exp_page = 3'd3;
    wr0 = oam_wr_cnt; done0 = done_cnt;
    start_dma(3'd3);
    check("stall_after_start", 32'(o_cpu_stall), 32'd1);
    check("busy_after_start", 32'(o_dma_busy), 32'd1);
    wait_idle("dma1_timeout");
    check("dma1_writes", 32'(oam_wr_cnt - wr0), 32'd256);
    check("dma1_order", 32'(order_err), 32'd0);
    check("dma1_oam0", 32'(oam_mem[0]), 32'h5A);
    check("dma1_oam255", 32'(oam_mem[255]), 32'hA5);
    check("dma1_data", 32'(count_mismatch()), 32'd0);
    check("dma1_stall_len", 32'(last_run), 32'd259);
    check("dma1_done_cnt", 32'(done_cnt - done0), 32'd1);
    check("dma1_done_last", 32'(run_at_done), 32'd259);

    // CPU write to source page in the same cycle as start
    i_cpu_ce = 1'b1; i_cpu_rnw = 1'b0; i_cpu_addr = 11'h300; i_cpu_wdata = 8'h77;
    start_dma(3'd3);
    i_cpu_ce = 1'b0; i_cpu_rnw = 1'b1;
    wait_idle("dma2_timeout");
    exp_oam[0] = 8'h77;
    check("dma2_first_byte", 32'(oam_mem[0]), 32'h77);
    check("dma2_data", 32'(count_mismatch()), 32'd0);

    // Second start mid-transfer is ignored
    for (int i = 0; i < 256; i++) cpu_write({3'd5, 8'(i)}, 8'(i) ^ 8'hC3);
    wr0 = oam_wr_cnt; done0 = done_cnt; bad0 = bad_acc;
    start_dma(3'd3);
    tick(39);
    start_dma(3'd5);
    wait_idle("dma3_timeout");
    check("dma3_writes", 32'(oam_wr_cnt - wr0), 32'd256);
    check("dma3_data", 32'(count_mismatch()), 32'd0);
    check("dma3_done_cnt", 32'(done_cnt - done0), 32'd1);
    check("dma3_stall_len", 32'(last_run), 32'd259);
    check("dma3_bad_acc", 32'(bad_acc - bad0), 32'd0);

    // CPU read data held through DMA; stalled CPU write never reaches WRAM
    cpu_write(11'h010, 8'h3C);
    cpu_read(11'h010);
    check("cpu_rd_010", 32'(o_cpu_rdata), 32'h3C);
    bad0 = bad_acc;
    start_dma(3'd3);
    tick(10);
    i_cpu_ce = 1'b1; i_cpu_rnw = 1'b0; i_cpu_addr = 11'h010; i_cpu_wdata = 8'hEE;
    tick(1);
    check("stall_ram_rnw", 32'(o_ram_rnw), 32'd1);
    tick(100);
    check("rdata_mid_dma", 32'(o_cpu_rdata), 32'h3C);
    i_cpu_ce = 1'b0; i_cpu_rnw = 1'b1;
    wait_idle("dma4_timeout");
    check("dma4_bad_acc", 32'(bad_acc - bad0), 32'd0);
    check("rdata_after_dma", 32'(o_cpu_rdata), 32'h3C);
    cpu_read(11'h010);
    check("cpu_rd_010_again", 32'(o_cpu_rdata), 32'h3C);

    // Reset at OAM index 100, then a fresh full transfer
    wr0 = oam_wr_cnt;
    start_dma(3'd3);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (o_oam_we && o_oam_addr == 8'd100) found = 1'b1;
      else tick(1);
    end
    check("reach_idx100", 32'(found), 32'd1);
    i_reset = 1'b1;
    tick(1);
    check("abort_oam_we", 32'(o_oam_we), 32'd0);
    check("abort_stall", 32'(o_cpu_stall), 32'd0);
    check("abort_busy", 32'(o_dma_busy), 32'd0);
    i_reset = 1'b0;
    tick(2);
    check("abort_writes", 32'(oam_wr_cnt - wr0), 32'd101);
    wr0 = oam_wr_cnt; done0 = done_cnt;
    start_dma(3'd3);
    wait_idle("dma5_timeout");
    check("dma5_writes", 32'(oam_wr_cnt - wr0), 32'd256);
    check("dma5_data", 32'(count_mismatch()), 32'd0);
    check("dma5_stall_len", 32'(last_run), 32'd259);
    check("dma5_done_cnt", 32'(done_cnt - done0), 32'd1);
    check("order_total", 32'(order_err), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/wram_oam_dma_ctrl.md
Name: wram_oam_dma_ctrl

Overview:
- Owns the single port of the 2KB CPU work RAM and shares it between the CPU and a sprite (OAM) DMA engine.
- When the CPU triggers DMA, the block stalls the CPU and streams one 256-byte WRAM page into OAM at 1 byte/cycle.
- It accounts for the RAM's synchronous 1-cycle read latency.
- Sits between the CPU bus decoder, the 2KB WRAM and the PPU OAM write port.

Parameters:
- DMA_LEN, 256, bytes per transfer; legal 1..256; OAM index runs 0..DMA_LEN-1.
- ALIGN_CYCLES, 1, idle stall cycles between start acceptance and first DMA read; legal 0..3.

Ports:
- i_clk_cpu  in  1  CPU clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cpu_ce  in  1  CPU requests a WRAM access this cycle.
- i_cpu_rnw  in  1  1 = read, 0 = write.
- i_cpu_addr  in  11  CPU WRAM address.
- i_cpu_wdata  in  8  CPU write data.
- o_cpu_rdata  out  8  CPU read data; valid the cycle after a granted read, held otherwise.
- o_cpu_stall  out  1  CPU must hold its bus; high whenever the DMA FSM is not IDLE.
- i_dma_start  in  1  single-cycle DMA trigger.
- i_dma_page  in  3  source page; source address = {page, index[7:0]}.
- o_dma_busy  out  1  high from the cycle after start acceptance until DONE completes.
- o_dma_done  out  1  1-cycle pulse at end of transfer.
- o_ram_ce, o_ram_rnw  out  1,1  WRAM control.
- o_ram_addr  out  11  WRAM address.
- o_ram_wdata  out  8  WRAM write data.
- i_ram_rdata  in  8  WRAM registered read data (1-cycle latency).
- o_oam_we  out  1  OAM write strobe.
- o_oam_addr  out  8  OAM byte index.
- o_oam_wdata  out  8  OAM write data.

Behaviour:
- Reset values:
  - FSM IDLE.
  - o_cpu_stall, o_dma_busy, o_dma_done, o_oam_we = 0.
  - o_cpu_rdata, o_oam_addr, o_oam_wdata = 0.
  - o_ram_ce = 0, o_ram_rnw = 1.
- Reset mid-transfer aborts immediately; no further OAM writes; the OAM keeps any partial content.
- FSM states: IDLE -> ALIGN -> XFER -> DRAIN -> DONE -> IDLE.
- IDLE:
  - RAM port is a combinational passthrough of the CPU signals (ce, rnw, addr, wdata).
  - i_dma_start=1 latches i_dma_page, clears index, and moves to ALIGN; if ALIGN_CYCLES=0, moves straight to XFER.
  - A CPU access in the same cycle as start is still granted and completes first. A same-cycle CPU write to the source page is visible to the DMA.
- ALIGN: counts ALIGN_CYCLES cycles; o_ram_ce=0; CPU stalled.
- XFER:
  - Each cycle drives o_ram_ce=1, rnw=1, addr={page,index}, then index++.
  - After issuing index DMA_LEN-1, goes to DRAIN.
- Read pipeline:
  - Every DMA read issued at cycle t produces at t+1: o_oam_we=1, o_oam_addr=index issued at t, o_oam_wdata=i_ram_rdata.
  - This write is registered so OAM sees it at t+1, aligned with rdata.
- DRAIN: o_ram_ce=0; the final OAM write occurs here.
- DONE: o_dma_done=1 for exactly this cycle; o_cpu_stall still 1; next state IDLE.
- Cycle accounting: start accepted at cycle S; o_cpu_stall high from S+1 through S+ALIGN_CYCLES+DMA_LEN+2 inclusive; exactly DMA_LEN OAM writes in strictly increasing index order.
- Stall and busy:
  - o_cpu_stall = (state != IDLE), combinational from the state register.
  - o_dma_busy equals o_cpu_stall.
  - While stalled, CPU ce/rnw/addr/wdata are ignored and never reach WRAM.
- Start pulses while not IDLE are ignored, with no queuing and no restart.
- Index is 8 bits. With DMA_LEN=256, index wraps 255->0 on the final increment; the source page never changes mid-transfer.
- o_cpu_rdata:
  - A 1-bit flag records "CPU read granted last cycle".
  - When the flag is set, o_cpu_rdata follows i_ram_rdata and is captured into a hold register.
  - Otherwise o_cpu_rdata outputs the hold register, so DMA traffic never disturbs it.
- CPU writes through the controller have the same 1-cycle commit timing as direct WRAM access.

Test Plan:
- Reset, then CPU write 0xA5 to 0x123, then read 0x123 -> o_cpu_rdata=0xA5 on the cycle after the read; o_cpu_stall=0 throughout.
- Preload page 3 with byte[i]=i^0x5A, pulse start with page=3 (DMA_LEN=256, ALIGN_CYCLES=1) -> 256 OAM writes, addr 0..255, data i^0x5A; stall high for exactly 259 cycles; o_dma_done pulses once on the last stall cycle.
- CPU write 0x77 to 0x300 in the same cycle as start(page=3) -> first OAM write data = 0x77.
- Second start pulse at cycle 40 of the transfer, page=5 -> ignored; all data still from page 3; a single o_dma_done pulse.
- CPU read 0x010 returns 0x3C, then a DMA runs -> o_cpu_rdata holds 0x3C through and after the DMA; CPU ce asserted during the stall produces no WRAM access.
- Assert i_reset at OAM index 100 -> next cycle o_oam_we=0, stall=0, FSM IDLE; a fresh start afterwards performs a complete 256-byte transfer.
